// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared constants, segment table and converter FSM states
//
// Package display_pkg
//   SEG_BLANK / SEG_DASH : active-low segment patterns, bit order [0:6] = a..g
//   OVF_LIMIT            : largest value that fits four decimal digits
//   conv_state_t         : IDLE / CONV / COMMIT states of the BCD converter
//   digit_seg()          : 0..9 to active-low segment pattern; other codes go blank
package display_pkg;

    localparam logic [0:6]  SEG_BLANK = 7'b1111111;
    localparam logic [0:6]  SEG_DASH  = 7'b1111110;
    localparam logic [15:0] OVF_LIMIT = 16'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [0:6] digit_seg(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - value/load/blank inputs and display pin outputs
//
// Signals
//   value [15:0] : binary value to display
//   load         : capture request for value
//   blank        : force display dark
//   seg [0:6]    : segments a..g, active-low
//   an [3:0]     : digit enables, active-low one-hot, an[0] = units
//   busy / done  : conversion in progress / one-cycle commit pulse
// Modports: master drives value/load/blank, slave (the controller) drives the rest.
interface display_scan_ctrl_if;
    logic [15:0] value;
    logic        load;
    logic        blank;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        done;

    modport master (output value, load, blank, input seg, an, busy, done);
    modport slave  (input value, load, blank, output seg, an, busy, done);
endinterface

// File: rtl/display_scan_ctrl_bin2bcd_seq.sv
// rtl/display_scan_ctrl_bin2bcd_seq.sv - iterative shift-and-add-3 binary to BCD converter
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   start      : accepted only in IDLE; captures bin
//   bin [15:0] : binary input
//   busy       : high from the capture edge until the commit edge
//   done       : high for the single cycle the FSM sits in COMMIT
//   bcd [19:0] : five BCD nibbles, valid while done is high
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_t state;
    logic [3:0]  iter;
    logic [35:0] sh;     // {bcd[19:0], bin[15:0]}
    logic [19:0] adj;

    // Add 3 to every nibble >= 5 so the following shift carries into the next decade.
    always_comb begin
        adj = sh[35:16];
        for (int i = 0; i < 5; i++) begin
            if (sh[16+4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = sh[16+4*i +: 4] + 4'd3;
        end
    end

    assign bcd = sh[35:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            iter  <= 4'd0;
            sh    <= 36'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh    <= {20'd0, bin};
                        iter  <= 4'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sh   <= {adj, sh[15:0]} << 1;
                    iter <= iter + 4'd1;
                    if (iter == 4'd15) begin
                        state <= COMMIT;
                        done  <= 1'b1;
                    end
                end
                COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed 7-segment driver with sequential BCD conversion
//
// Parameters
//   REFRESH_DIV : cycles each digit stays enabled (>= 2)
//   LZ_SUPPRESS : 1 = blank leading zeros (digit 0 always shown)
// Ports
//   clk, rst : clock, synchronous active-high reset
//   dif      : slave side of display_scan_ctrl_if (value/load/blank in, seg/an/busy/done out)
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   dif
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [3:0]       digit [4];
    logic             valid;
    logic             ovf;
    logic             ovf_pend;
    logic             cv_start;
    logic             cv_busy;
    logic             cv_done;
    logic [19:0]      cv_bcd;
    logic [3:0]       lz_blank;
    logic [0:6]       sel_seg;
    logic             unused_bcd_top;

    assign cv_start = dif.load & ~cv_busy;
    assign dif.busy = cv_busy;

    // The fifth BCD nibble only matters for overflow, which is judged from the captured value.
    assign unused_bcd_top = &{1'b0, cv_bcd[19:16]};

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (cv_start),
        .bin   (dif.value),
        .busy  (cv_busy),
        .done  (cv_done),
        .bcd   (cv_bcd)
    );

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (digit[3] == 4'd0);
        lz_blank[2] = lz_blank[3] && (digit[2] == 4'd0);
        lz_blank[1] = lz_blank[2] && (digit[1] == 4'd0);
    end

    always_comb begin
        sel_seg = digit_seg(digit[idx]);
        if (ovf)
            sel_seg = SEG_DASH;
        else if ((LZ_SUPPRESS != 0) && lz_blank[idx])
            sel_seg = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            idx      <= 2'd0;
            for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            dif.seg  <= SEG_BLANK;
            dif.an   <= 4'b1111;
            dif.done <= 1'b0;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 2'd1;
            end else begin
                div <= div + 1'b1;
            end

            if (cv_start)
                ovf_pend <= (dif.value > OVF_LIMIT);

            dif.done <= cv_done;
            if (cv_done) begin
                for (int i = 0; i < 4; i++) digit[i] <= cv_bcd[4*i +: 4];
                ovf   <= ovf_pend;
                valid <= 1'b1;
            end

            // an and seg come from the same index on the same edge, so no ghosting.
            if (dif.blank || !valid) begin
                dif.an  <= 4'b1111;
                dif.seg <= SEG_BLANK;
            end else begin
                dif.an  <= ~(4'b0001 << idx);
                dif.seg <= sel_seg;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] v_value = 16'd0;
    logic        v_load = 1'b0;
    logic        v_blank = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl_if if1 ();
    display_scan_ctrl_if if0 ();

    assign if1.value = v_value;
    assign if1.load  = v_load;
    assign if1.blank = v_blank;
    assign if0.value = v_value;
    assign if0.load  = v_load;
    assign if0.blank = v_blank;

    display_scan_ctrl #(.REFRESH_DIV(R), .LZ_SUPPRESS(1)) u_lz1 (.clk(clk), .rst(rst), .dif(if1));
    display_scan_ctrl #(.REFRESH_DIV(R), .LZ_SUPPRESS(0)) u_lz0 (.clk(clk), .rst(rst), .dif(if0));

    logic [0:6] segt [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
    int p10 [4] = '{1, 10, 100, 1000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: displayed decimal number, digit i = (v / 10^i) % 10.
    function automatic logic [0:6] mseg(input int v, input int i, input bit lz);
        if (v > 9999) return 7'b1111110;
        if (lz && i > 0 && v < p10[i]) return 7'b1111111;
        return segt[(v / p10[i]) % 10];
    endfunction

    int         m_e, m_cnt, m_disp, m_pend;
    bit         m_valid;
    logic [3:0] exp_an;
    logic [0:6] exp_seg1, exp_seg0;
    logic       exp_busy, exp_done;

    always @(posedge clk) begin
        if (rst) begin
            m_e <= 0; m_cnt <= 0; m_valid <= 1'b0;
            exp_an <= 4'b1111; exp_seg1 <= 7'b1111111; exp_seg0 <= 7'b1111111;
            exp_busy <= 1'b0; exp_done <= 1'b0;
        end else begin
            if (v_blank || !m_valid) begin
                exp_an <= 4'b1111; exp_seg1 <= 7'b1111111; exp_seg0 <= 7'b1111111;
            end else begin
                exp_an   <= ~(4'b0001 << ((m_e / R) % 4));
                exp_seg1 <= mseg(m_disp, (m_e / R) % 4, 1'b1);
                exp_seg0 <= mseg(m_disp, (m_e / R) % 4, 1'b0);
            end
            m_e <= m_e + 1;
            if (m_cnt > 0) begin
                m_cnt    <= m_cnt - 1;
                exp_busy <= (m_cnt > 1);
                exp_done <= (m_cnt == 1);
                if (m_cnt == 1) begin
                    m_disp <= m_pend; m_valid <= 1'b1;
                end
            end else begin
                exp_done <= 1'b0;
                exp_busy <= v_load;
                if (v_load) begin
                    m_cnt <= 17; m_pend <= int'(v_value);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an_lz1", 32'(if1.an), 32'(exp_an));
            chk("seg_lz1", 32'(if1.seg), 32'(exp_seg1));
            chk("an_lz0", 32'(if0.an), 32'(exp_an));
            chk("seg_lz0", 32'(if0.seg), 32'(exp_seg0));
            chk("busy", 32'(if1.busy), 32'(exp_busy));
            chk("done", 32'(if1.done), 32'(exp_done));
        end
    end

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        v_value = v; v_load = 1'b1;
        @(negedge clk);
        v_load = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (if1.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (if1.done !== 1'b1) chk("done_timeout", 32'(if1.done), 32'd1);
    endtask

    // Waits for the given digit enable on the LZ=1 instance, then checks both instances' segments.
    task automatic check_digit(input string name, input logic [3:0] an_exp,
                               input logic [0:6] s1, input logic [0:6] s0);
        int n = 0;
        @(negedge clk);
        while (if1.an !== an_exp && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_an"}, 32'(if1.an), 32'(an_exp));
        chk({name, "_seg1"}, 32'(if1.seg), 32'(s1));
        chk({name, "_seg0"}, 32'(if0.seg), 32'(s0));
    endtask

    initial begin
        int busy_n, done_n;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(if1.an), 32'hF);
        chk("rst_seg", 32'(if1.seg), 32'h7F);
        chk("rst_busy", 32'(if1.busy), 32'd0);
        chk("rst_done", 32'(if1.done), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1234: latency and scan order
        do_load(16'd1234);
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 30 && done_n == 0; i++) begin
            if (if1.busy === 1'b1) busy_n++;
            if (if1.done === 1'b1) done_n++;
            if (done_n == 0) @(negedge clk);
        end
        chk("busy_cycles", 32'(busy_n), 32'd17);
        chk("done_seen", 32'(done_n), 32'd1);
        chk("done_busy_low", 32'(if1.busy), 32'd0);
        check_digit("d0_1234", 4'b1110, 7'b1001100, 7'b1001100);
        check_digit("d1_1234", 4'b1101, 7'b0000110, 7'b0000110);
        check_digit("d2_1234", 4'b1011, 7'b0010010, 7'b0010010);
        check_digit("d3_1234", 4'b0111, 7'b1001111, 7'b1001111);

        do_load(16'd10000); wait_done();
        check_digit("d0_10000", 4'b1110, 7'b1111110, 7'b1111110);
        check_digit("d3_10000", 4'b0111, 7'b1111110, 7'b1111110);
        do_load(16'd65535); wait_done();
        check_digit("d1_65535", 4'b1101, 7'b1111110, 7'b1111110);
        do_load(16'd9999); wait_done();
        check_digit("d0_9999", 4'b1110, 7'b0001100, 7'b0001100);
        check_digit("d3_9999", 4'b0111, 7'b0001100, 7'b0001100);

        do_load(16'd7); wait_done();
        check_digit("d0_7", 4'b1110, 7'b0001111, 7'b0001111);
        check_digit("d2_7", 4'b1011, 7'b1111111, 7'b0000001);
        check_digit("d3_7", 4'b0111, 7'b1111111, 7'b0000001);
        do_load(16'd0); wait_done();
        check_digit("d0_0", 4'b1110, 7'b0000001, 7'b0000001);
        check_digit("d1_0", 4'b1101, 7'b1111111, 7'b0000001);

        // load while busy is ignored
        @(negedge clk);
        v_value = 16'd42; v_load = 1'b1;
        @(negedge clk);
        v_load = 1'b0;
        repeat (4) @(negedge clk);
        v_value = 16'd99; v_load = 1'b1;
        @(negedge clk);
        v_load = 1'b0;
        done_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (if1.done === 1'b1) done_n++;
            @(negedge clk);
        end
        chk("busy_load_done_count", 32'(done_n), 32'd1);
        check_digit("d0_42", 4'b1110, 7'b0010010, 7'b0010010);
        check_digit("d1_42", 4'b1101, 7'b1001100, 7'b1001100);

        // blank mid-scan
        v_blank = 1'b1;
        @(negedge clk);
        chk("blank_an", 32'(if1.an), 32'hF);
        chk("blank_seg", 32'(if1.seg), 32'h7F);
        repeat (3) @(negedge clk);
        v_blank = 1'b0;
        repeat (6) @(negedge clk);

        // reset mid-conversion
        @(negedge clk);
        v_value = 16'd1234; v_load = 1'b1;
        @(negedge clk);
        v_load = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_an", 32'(if1.an), 32'hF);
        chk("rst_mid_busy", 32'(if1.busy), 32'd0);
        done_n = 0;
        for (int i = 0; i < 25; i++) begin
            if (if1.done === 1'b1) done_n++;
            chk("rst_mid_dark", 32'(if1.an), 32'hF);
            @(negedge clk);
        end
        chk("rst_mid_no_done", 32'(done_n), 32'd0);

        do_load(16'd5); wait_done();
        check_digit("d0_5", 4'b1110, 7'b0100100, 7'b0100100);
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Drives a 4-digit, time-multiplexed 7-segment display from a 16-bit binary value, sharing one segment bus across all four digits.
- Binary-to-BCD conversion is sequential (shift-and-add-3, 16 iterations).
- Digits are scanned with a programmable refresh divider.
- Replaces the parallel per-digit decoders where pin count matters. Sits between the arithmetic datapath and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays enabled (>=2).
- LZ_SUPPRESS, 1: 1 = blank leading zeros (digit 0 always shown); 0 = show all four digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  16  unsigned binary value to display
- load  in  1  capture request for value; sampled on the rising edge
- blank  in  1  1 = display dark (seg all ones, an all ones)
- seg  out  7  [0:6] = a..g, active-low
- an  out  4  digit enables, active-low one-hot; an[0] = units digit
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when new digits are committed

Behaviour:
- Reset values: seg=7'b1111111, an=4'b1111, busy=0, done=0, digit registers=0, valid=0, ovf=0, scan index=0, divider=0, FSM=IDLE.
- Reset mid-conversion aborts the conversion. Nothing is committed.
- Segment patterns, [0:6]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - dash=1111110, blank=1111111
- FSM has three states: IDLE, CONV, COMMIT.
- IDLE:
  - load=1 at edge k captures value into the shift register.
  - ovf is set to (value > 9999).
  - Moves to CONV with iteration count 0; busy=1 after edge k.
- CONV:
  - Each cycle adds 3 to every BCD nibble >=5, then shifts the combined register left by 1.
  - After 16 iterations (edges k+1..k+16) moves to COMMIT.
  - The BCD field is 20 bits so that 65535 converts without loss.
- COMMIT (edge k+17):
  - Writes the low 4 BCD nibbles to the digit registers and the latched ovf to the display ovf flag.
  - Sets valid=1, pulses done=1 for exactly one cycle, returns to IDLE, clears busy.
  - Latency from load to new digits is 17 cycles, fixed and independent of the value.
- load while busy=1 is ignored: value is not captured and the conversion in flight is unaffected.
- Scan:
  - The divider counts 0..REFRESH_DIV-1 continuously from reset.
  - On wrap, the scan index goes 0->1->2->3->0.
  - The divider and index keep running regardless of blank, valid or the FSM.
- Registered outputs, updated every cycle from the current index:
  - If blank=1 or valid=0: an=1111, seg=blank.
  - Otherwise an[index]=0, other an bits=1, and seg is the pattern for digit[index].
  - an and seg change on the same edge, so there is no ghosting cycle.
- Overflow: while the display ovf flag is set, every digit shows dash.
- LZ_SUPPRESS=1: each digit above the most significant non-zero digit shows blank, but its an bit is still asserted. Digit 0 is never suppressed (value 0 displays "0").
- New digits committed mid-scan take effect on the next output update. The scan phase is not reset.
- blank has no effect on conversion or done.

Decomposition:
- Package display_pkg holds:
  - SEG_BLANK and SEG_DASH constants
  - the 10-entry digit-to-segment pattern function
  - the FSM state enum
  - the 9999 overflow limit
- One sub-module, bin2bcd_seq: the iterative converter with start/busy/done handshake, 16-bit input, 20-bit BCD output.
- The scan divider, output mux and leading-zero logic stay in the top level.

Test Plan:
- Reset, then load 1234 with REFRESH_DIV=4, LZ=1 -> busy high for cycles k+1..k+17, done pulses at k+17.
- In the same run, scan shows an=1110/seg=1001100, an=1101/0000110, an=1011/0010010, an=0111/1001111, each for 4 cycles.
- Load 10000 -> after done, all four digits show seg=1111110.
- Load 65535 -> dashes; load 9999 -> four 0001100.
- Load 7, LZ=1 -> digit 0 shows 0001111 and digits 1-3 show 1111111 while their an bits still cycle. With LZ=0, digits 1-3 show 0000001. Load 0 -> digit 0 shows 0000001.
- Load 42, then assert load=1 with value=99 at k+5 -> ignored; done fires once at k+17 and the display shows 42.
- blank=1 mid-scan -> next cycle an=1111, seg=1111111. Deassert -> resumes at the current scan index.
- Load 1234, then assert rst at k+8 -> all outputs return to reset values, no done pulse, display stays dark (valid=0) until the next load completes.
